code_entry_ctrl: RTL and testbench
==================================

# code_entry_ctrl

Password-entry controller that sequences the debounced push-button datapath into a code-check state machine. Takes four debounced button levels (one `debouncer` instance per button, upstream), converts them to press events, collects a 4-symbol entry, compares it against a parameterized code, and drives unlock, error and lockout indications. Sits between the per-button debouncers and the board LEDs/lock output.

## Interface
- `CODE`, 8'b11_10_01_00: expected sequence, 2 bits per symbol; first symbol is `CODE[1:0]`, fourth is `CODE[7:6]`.
- `MAX_FAILS`, 2'd3: consecutive failures that trigger lockout; legal range 1..3.
- `UNLOCK_CYCLES`, 32'd100_000_000: cycles `unlocked` stays high.
- `LOCKOUT_CYCLES`, 32'd500_000_000: cycles spent in lockout.
- `ENTRY_TIMEOUT`, 32'd300_000_000: idle cycles allowed between presses once entry has started.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  4  debounced button levels; `btn[i]` encodes symbol i.
- `unlocked`  out  1  high while in UNLOCK.
- `error`  out  1  one-cycle pulse on failed check or entry timeout.
- `locked_out`  out  1  high while in LOCKOUT.
- `digit_count`  out  3  symbols captured in the current entry, 0..4.
- `fail_count`  out  2  consecutive failures.

## Operation
- Edge detect: `btn_q` registers `btn`. Press vector is `btn & ~btn_q`. Reset loads `btn_q` with 4'b1111, so a button held through reset produces no press.
- Valid press: exactly one bit set, giving symbol i. Two or more bits set in one cycle is an invalid press. It consumes a digit slot and forces a mismatch.
- Incremental compare: a `mismatch` flag is set when symbol k differs from `CODE[2k+1:2k]` or the press is invalid. Entered symbols are not stored.
- States:
  - IDLE: `digit_count`=0, `mismatch`=0. Any press captures digit 0 and moves to ENTRY, or to CHECK if it was the 4th digit.
  - ENTRY: each press increments `digit_count`. The press that brings it to 4 moves to CHECK. The idle timer resets on every press. Timer reaching `ENTRY_TIMEOUT` -> IDLE with an `error` pulse and digits cleared; `fail_count` is unchanged.
  - CHECK: lasts one cycle. If `mismatch`=0 -> UNLOCK and `fail_count` <= 0. Otherwise `fail_count` increments with an `error` pulse. Then go to LOCKOUT if the new count equals `MAX_FAILS`, else to IDLE.
  - UNLOCK: `unlocked`=1 for exactly `UNLOCK_CYCLES` cycles, then IDLE.
  - LOCKOUT: `locked_out`=1 for exactly `LOCKOUT_CYCLES` cycles, then IDLE with `fail_count` <= 0.
- Presses in CHECK, UNLOCK and LOCKOUT are ignored and not queued. `btn_q` keeps tracking, so a button held across the exit does not fire.
- Timers are one shared 32-bit counter, cleared on every state change. It does not wrap: it saturates at its terminal count.

## Timing
- Reset values: state IDLE, `unlocked`=0, `error`=0, `locked_out`=0, `digit_count`=0, `fail_count`=0, timer=0.
- All outputs are registered, with no combinational path from `btn`.
- A press is detected at the first edge that samples `btn[i]`=1. `digit_count` updates at that same edge.
- 4th press at edge E: state=CHECK after E. `unlocked`, or the `error` pulse, goes high after E+1.
- `unlocked` high for cycles E+1 .. E+UNLOCK_CYCLES. IDLE after E+UNLOCK_CYCLES+1.
- Timeout: the `error` pulse is asserted in the cycle after the timer hits `ENTRY_TIMEOUT`.
- Reset mid-operation (any state) returns to the full reset values on the next edge, including `fail_count`. A lockout cannot be shortened except by reset.

## Test plan
Parameters for all scenarios: `UNLOCK_CYCLES`=8, `LOCKOUT_CYCLES`=16, `ENTRY_TIMEOUT`=20, `MAX_FAILS`=3, `CODE`=8'b11_10_01_00.

- Correct entry: press 0,1,2,3, each a 3-cycle pulse 5 cycles apart. Expect `digit_count` 1..4, `unlocked` high for exactly 8 cycles starting 1 cycle after the 4th press, `error` never asserted, `fail_count`=0.
- Wrong entry: press 0,1,3,2. Expect a single-cycle `error` 1 cycle after the 4th press, `fail_count`=1, return to IDLE, `unlocked` stays 0.
- Lockout: three wrong entries. Expect `fail_count` 1,2,3, then `locked_out` high for 16 cycles. Presses during lockout leave `digit_count` at 0. Afterwards `fail_count`=0, and a correct entry unlocks.
- Timeout and invalid press:
  - Press 0, then wait 21 cycles. Expect an `error` pulse, `digit_count`=0, `fail_count` unchanged.
  - Next, press `btn`=4'b0011 simultaneously, then 1,2,3. Expect CHECK to fail.
- Reset and hold:
  - Hold `btn[0]` through reset release. Expect no press.
  - Assert reset during UNLOCK. Expect `unlocked`=0 the next cycle, all counters 0.

Source files
------------

// File: rtl/code_entry_ctrl.sv
// Password-entry controller: turns debounced button levels into press events,
// checks a 4-symbol entry against CODE and drives unlock/error/lockout outputs.
module code_entry_ctrl #(
    parameter logic [7:0]  CODE           = 8'b11_10_01_00,
    parameter logic [1:0]  MAX_FAILS      = 2'd3,
    parameter logic [31:0] UNLOCK_CYCLES  = 32'd100_000_000,
    parameter logic [31:0] LOCKOUT_CYCLES = 32'd500_000_000,
    parameter logic [31:0] ENTRY_TIMEOUT  = 32'd300_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [2:0] digit_count,
    output logic [1:0] fail_count
);

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCK, LOCKOUT} state_t;

    state_t      state, state_next;
    logic [3:0]  btn_q;
    logic [3:0]  press;
    logic        any_press;
    logic        valid_press;
    logic [1:0]  sym;
    logic        sym_bad;
    logic        mismatch, mismatch_next;
    logic [31:0] timer, timer_next;
    logic        timer_clr;
    logic [2:0]  digit_next;
    logic [1:0]  fail_next;
    logic        error_next;

    assign press = btn & ~btn_q;

    always_comb begin
        any_press   = |press;
        valid_press = 1'b0;
        sym         = '0;
        case (press)
            4'b0001: begin valid_press = 1'b1; sym = 2'd0; end
            4'b0010: begin valid_press = 1'b1; sym = 2'd1; end
            4'b0100: begin valid_press = 1'b1; sym = 2'd2; end
            4'b1000: begin valid_press = 1'b1; sym = 2'd3; end
            default: ;
        endcase
        // Multi-button presses still consume a slot but can never match.
        sym_bad = !valid_press || (sym != CODE[{digit_count[1:0], 1'b0} +: 2]);
    end

    always_comb begin
        state_next    = state;
        digit_next    = digit_count;
        mismatch_next = mismatch;
        fail_next     = fail_count;
        error_next    = 1'b0;
        timer_clr     = 1'b0;
        case (state)
            IDLE: begin
                digit_next    = '0;
                mismatch_next = 1'b0;
                if (any_press) begin
                    digit_next    = 3'd1;
                    mismatch_next = sym_bad;
                    state_next    = ENTRY;
                end
            end
            ENTRY: begin
                if (any_press) begin
                    digit_next    = digit_count + 3'd1;
                    mismatch_next = mismatch | sym_bad;
                    timer_clr     = 1'b1;
                    if (digit_count == 3'd3)
                        state_next = CHECK;
                end else if (timer >= ENTRY_TIMEOUT) begin
                    digit_next = '0;
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                digit_next = '0;
                if (!mismatch) begin
                    fail_next  = '0;
                    state_next = UNLOCK;
                end else begin
                    fail_next  = fail_count + 2'd1;
                    error_next = 1'b1;
                    state_next = (fail_count + 2'd1 == MAX_FAILS) ? LOCKOUT : IDLE;
                end
            end
            UNLOCK: begin
                if (timer >= UNLOCK_CYCLES - 32'd1)
                    state_next = IDLE;
            end
            LOCKOUT: begin
                if (timer >= LOCKOUT_CYCLES - 32'd1) begin
                    fail_next  = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state || timer_clr)
            timer_next = '0;
        else if (timer != '1)
            timer_next = timer + 32'd1;
        else
            timer_next = timer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            btn_q       <= 4'b1111;
            timer       <= '0;
            mismatch    <= 1'b0;
            digit_count <= '0;
            fail_count  <= '0;
            error       <= 1'b0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            state       <= state_next;
            btn_q       <= btn;
            timer       <= timer_next;
            mismatch    <= mismatch_next;
            digit_count <= digit_next;
            fail_count  <= fail_next;
            error       <= error_next;
            unlocked    <= (state_next == UNLOCK);
            locked_out  <= (state_next == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Scoreboard bench for code_entry_ctrl: directed scenarios plus random entries
// checked against an entry-level model of the code lock.
module tb_code_entry_ctrl;

    localparam logic [7:0] CODE = 8'b11_10_01_00;
    localparam int UNL  = 8;
    localparam int LOCK = 16;
    localparam int TMO  = 20;
    localparam int MAXF = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn = 4'b0001;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    code_entry_ctrl #(
        .CODE(CODE),
        .MAX_FAILS(2'd3),
        .UNLOCK_CYCLES(32'd8),
        .LOCKOUT_CYCLES(32'd16),
        .ENTRY_TIMEOUT(32'd20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .unlocked(unlocked),
        .error(error),
        .locked_out(locked_out),
        .digit_count(digit_count),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // kind 0 = unlock, 1 = error pulse; cyc = edge after which it must appear
    typedef struct {int kind; int lock; int fc; int cyc;} exp_t;
    exp_t       exp_q[$];
    exp_t       me;
    logic [3:0] ent[$];
    int tests = 0, fails = 0;
    int cyc_n = 0, since = 0, fc_m = 0, accept_from = 0;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    function automatic logic [3:0] code_mask(int k);
        int s;
        s = (CODE >> (2 * k)) & 3;
        return 4'b0001 << s;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        cyc_n++;
        since++;
        if (ent.size() > 0 && since == TMO + 1) begin
            exp_q.push_back('{kind: 1, lock: 0, fc: fc_m, cyc: cyc_n});
            ent.delete();
        end
    endtask

    task automatic press(input logic [3:0] mask, input int len, input int gap);
        int e;
        bit ok;
        btn = mask;
        @(posedge clk); #1;
        cyc_n++;
        since++;
        e = cyc_n;
        if (e >= accept_from) begin
            ent.push_back(mask);
            since = 0;
            chk("digit_count", digit_count, ent.size());
            if (ent.size() == 4) begin
                ok = 1;
                for (int k = 0; k < 4; k++)
                    if (ent[k] != code_mask(k)) ok = 0;
                if (ok) begin
                    exp_q.push_back('{kind: 0, lock: 0, fc: 0, cyc: e + 1});
                    fc_m = 0;
                    accept_from = e + UNL + 2;
                end else begin
                    fc_m++;
                    exp_q.push_back('{kind: 1, lock: int'(fc_m == MAXF), fc: fc_m, cyc: e + 1});
                    if (fc_m == MAXF) begin
                        fc_m = 0;
                        accept_from = e + LOCK + 2;
                    end else begin
                        accept_from = e + 2;
                    end
                end
                ent.delete();
            end
        end else begin
            chk("digit_count_ignored", digit_count, 0);
        end
        repeat (len - 1) tick();
        btn = '0;
        repeat (gap) tick();
    endtask

    task automatic enter(input logic [3:0] m0, m1, m2, m3);
        press(m0, 3, 2);
        press(m1, 3, 2);
        press(m2, 3, 2);
        press(m3, 3, 2);
    endtask

    // Monitor: pops an expectation whenever the DUT raises error or unlocked.
    bit prev_err = 0, prev_ul = 0, prev_lo = 0;
    int ul_run = 0, lo_run = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_err = 0; prev_ul = 0; prev_lo = 0;
            ul_run = 0; lo_run = 0;
        end else begin
            if (prev_err) chk("error_width", error, 0);
            if (error && !prev_err) begin
                if (exp_q.size() == 0) chk("unexpected_error", 1, 0);
                else begin
                    me = exp_q.pop_front();
                    chk("event_kind_err", 1, me.kind);
                    chk("event_cycle", cyc_n, me.cyc);
                    chk("fail_count_at_error", fail_count, me.fc);
                    chk("lockout_start", locked_out, me.lock);
                end
            end
            if (unlocked && !prev_ul) begin
                if (exp_q.size() == 0) chk("unexpected_unlock", 1, 0);
                else begin
                    me = exp_q.pop_front();
                    chk("event_kind_unlock", 0, me.kind);
                    chk("event_cycle", cyc_n, me.cyc);
                    chk("fail_count_at_unlock", fail_count, 0);
                end
            end
            if (locked_out && !prev_lo) chk("lockout_rise_with_error", error, 1);
            if (unlocked) ul_run++;
            else if (prev_ul) begin
                chk("unlock_length", ul_run, UNL);
                ul_run = 0;
            end
            if (locked_out) lo_run++;
            else if (prev_lo) begin
                chk("lockout_length", lo_run, LOCK);
                chk("fail_count_after_lockout", fail_count, 0);
                lo_run = 0;
            end
            prev_err = error; prev_ul = unlocked; prev_lo = locked_out;
        end
    end

    int         kind, nd;
    logic [3:0] m;

    initial begin
        // reset with btn[0] held through release
        repeat (3) tick();
        chk("reset_unlocked", unlocked, 0);
        chk("reset_error", error, 0);
        chk("reset_locked_out", locked_out, 0);
        chk("reset_digit_count", digit_count, 0);
        chk("reset_fail_count", fail_count, 0);
        reset = 1'b0;
        repeat (4) tick();
        chk("held_button_no_press", digit_count, 0);
        btn = '0;
        repeat (3) tick();

        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        repeat (20) tick();
        enter(4'b0001, 4'b0010, 4'b1000, 4'b0100);
        repeat (20) tick();
        chk("fail_count_after_wrong", fail_count, fc_m);

        // two more wrong entries reach MAX_FAILS; presses during lockout ignored
        enter(4'b0001, 4'b0001, 4'b0001, 4'b0001);
        repeat (20) tick();
        enter(4'b1000, 4'b0010, 4'b0100, 4'b1000);
        press(4'b0001, 3, 2);
        press(4'b0010, 3, 2);
        repeat (10) tick();
        chk("fail_count_post_lockout", fail_count, 0);
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        repeat (20) tick();

        // timeout, then an invalid two-button press
        press(4'b0001, 3, 2);
        repeat (25) tick();
        chk("timeout_digit_count", digit_count, 0);
        chk("timeout_fail_count", fail_count, fc_m);
        enter(4'b0011, 4'b0010, 4'b0100, 4'b1000);
        repeat (20) tick();

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                nd = $urandom_range(1, 3);
                for (int k = 0; k < nd; k++)
                    press(4'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom_range(1, 4));
                repeat (25) tick();
                chk("rand_timeout_digits", digit_count, 0);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (kind < 6) m = code_mask(k);
                    else m = 4'($urandom_range(1, 15));
                    press(m, $urandom_range(1, 3), $urandom_range(1, 4));
                end
                repeat (20) tick();
            end
        end

        // reset in the middle of an unlock
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        chk("unlocked_before_reset", unlocked, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        cyc_n++;
        chk("midreset_unlocked", unlocked, 0);
        chk("midreset_error", error, 0);
        chk("midreset_locked_out", locked_out, 0);
        chk("midreset_digit_count", digit_count, 0);
        chk("midreset_fail_count", fail_count, 0);
        reset = 1'b0;
        ent.delete();
        fc_m = 0;
        accept_from = 0;
        since = 0;
        repeat (3) tick();
        enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
        repeat (20) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
